histogram_accum_engine: RTL and testbench

//  Parametrised histogram accumulator: streams lines of packed pixels, bins each pixel, read-modify-writes packed bin counters in scratch memory.

---
 rtl/hist_pkg.sv | 28 ++
 rtl/hist_rmw_merge.sv | 49 ++++
 rtl/histogram_accum_engine.sv | 199 +++++++++++++++++++
 tb/tb_histogram_accum_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram accumulator engine.
//   state_t    : engine control states
//   *_DEF      : default values for the engine parameters
//   bin_index  : maps a pixel value to its histogram bin by dropping low bits
package hist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned PIX_W_DEF         = 8;
    localparam int unsigned PIX_PER_LINE_DEF  = 16;
    localparam int unsigned BIN_BITS_DEF      = 6;
    localparam int unsigned CNT_W_DEF         = 32;
    localparam int unsigned BINS_PER_WORD_DEF = 4;
    localparam int unsigned ADDR_W_DEF        = 16;

    // The bin is the top BIN_BITS bits of the pixel; shift = PIX_W - BIN_BITS.
    function automatic int unsigned bin_index(input logic [31:0] pixel,
                                              input int unsigned shift);
        return pixel >> shift;
    endfunction

endpackage

// File: rtl/hist_rmw_merge.sv
// Read-modify-write merge for one packed scratch line.
// Picks the freshest copy of the line being updated (the line in the write
// stage now, else the line written last cycle, else the scratch read data),
// then increments one counter field with saturation.
//   addr   : line address being updated
//   rdata  : line data returned by the scratch memory
//   w_*    : line currently in the write stage (newest history entry)
//   h_*    : line that was in the write stage one cycle earlier
//   field  : counter index inside the line
//   wdata  : updated line
//   sat    : the selected counter was already at its maximum
module hist_rmw_merge #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned BINS_PER_WORD = 4,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned FIELD_W       = 2
) (
    input  logic [ADDR_W-1:0]              addr,
    input  logic [BINS_PER_WORD*CNT_W-1:0] rdata,
    input  logic                           w_vld,
    input  logic [ADDR_W-1:0]              w_addr,
    input  logic [BINS_PER_WORD*CNT_W-1:0] w_data,
    input  logic                           h_vld,
    input  logic [ADDR_W-1:0]              h_addr,
    input  logic [BINS_PER_WORD*CNT_W-1:0] h_data,
    input  logic [FIELD_W-1:0]             field,
    output logic [BINS_PER_WORD*CNT_W-1:0] wdata,
    output logic                           sat
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [BINS_PER_WORD*CNT_W-1:0] sel;
    logic [CNT_W-1:0]               cur;

    always_comb begin
        sel = rdata;
        if (h_vld && (h_addr == addr)) sel = h_data;
        // The write-stage entry is newer than the history entry, so it wins.
        if (w_vld && (w_addr == addr)) sel = w_data;
        cur   = sel[field*CNT_W +: CNT_W];
        sat   = &cur;
        wdata = sel;
        wdata[field*CNT_W +: CNT_W] = sat_inc(cur);
    end

endmodule

// File: rtl/histogram_accum_engine.sv
// Histogram accumulator engine.
// Clears the scratch histogram, then streams packed pixel lines, bins every
// pixel and read-modify-writes the packed bin counters in scratch memory
// through a 3-stage R/M/W pipeline with forwarding of in-flight lines.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   start                   : begin clear pass and frame (only from IDLE)
//   in_valid/in_ready       : pixel line handshake, in_data packed pixels
//   in_last                 : marks the final line of the frame
//   scr_rd_en/addr, rdata   : scratch read port (data one cycle after strobe)
//   scr_wr_en/addr/wdata    : scratch write port
//   busy, done              : not IDLE / one-cycle end-of-frame pulse
//   sat_flag, pixel_count   : sticky counter saturation, pixels this frame
module histogram_accum_engine
    import hist_pkg::*;
#(
    parameter int unsigned PIX_W         = PIX_W_DEF,
    parameter int unsigned PIX_PER_LINE  = PIX_PER_LINE_DEF,
    parameter int unsigned BIN_BITS      = BIN_BITS_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned BINS_PER_WORD = BINS_PER_WORD_DEF,
    parameter int unsigned ADDR_W        = ADDR_W_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PIX_PER_LINE*PIX_W-1:0]   in_data,
    input  logic                            in_last,
    output logic                            scr_rd_en,
    output logic [ADDR_W-1:0]               scr_rd_addr,
    input  logic [BINS_PER_WORD*CNT_W-1:0]  scr_rdata,
    output logic                            scr_wr_en,
    output logic [ADDR_W-1:0]               scr_wr_addr,
    output logic [BINS_PER_WORD*CNT_W-1:0]  scr_wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            sat_flag,
    output logic [CNT_W-1:0]                pixel_count
);

    localparam int unsigned LINE_W    = BINS_PER_WORD * CNT_W;
    localparam int unsigned IN_W      = PIX_PER_LINE * PIX_W;
    localparam int unsigned SCR_DEPTH = (2 ** BIN_BITS) / BINS_PER_WORD;
    localparam int unsigned SHIFT     = PIX_W - BIN_BITS;
    localparam int unsigned FIELD_W   = (BINS_PER_WORD > 1) ? $clog2(BINS_PER_WORD) : 1;
    localparam int unsigned SER_W     = $clog2(PIX_PER_LINE + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  clr_addr;
    logic [IN_W-1:0]    ser_data;
    logic [SER_W-1:0]   ser_cnt;
    logic               accept;

    logic               vld_p0;
    logic [PIX_W-1:0]   pix_p0;
    int unsigned        bin_p0;
    logic [ADDR_W-1:0]  addr_p0;
    logic [FIELD_W-1:0] field_p0;

    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [FIELD_W-1:0] field_p1;
    logic [LINE_W-1:0]  merged_p1;
    logic               sat_p1;

    logic               vld_p2;
    logic [ADDR_W-1:0]  addr_p2;
    logic [LINE_W-1:0]  data_p2;

    logic               vld_p3;
    logic [ADDR_W-1:0]  addr_p3;
    logic [LINE_W-1:0]  data_p3;

    // Control FSM
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_addr == ADDR_W'(SCR_DEPTH - 1)) state_nxt = ST_ACCUM;
            ST_ACCUM: if (accept && in_last) state_nxt = ST_DRAIN;
            // Once the serializer is empty and M holds nothing, the W stage
            // is issuing the last write of the frame this cycle (or none).
            ST_DRAIN: if ((ser_cnt == '0) && !vld_p1) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || (state != ST_CLEAR)) clr_addr <= '0;
        else                              clr_addr <= clr_addr + ADDR_W'(1);
    end

    // Line serializer: a new line only enters once the previous one is fully out.
    assign in_ready = (state == ST_ACCUM) && (ser_cnt == '0);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset)       ser_cnt <= '0;
        else if (accept) ser_cnt <= SER_W'(PIX_PER_LINE);
        else if (vld_p0) ser_cnt <= ser_cnt - SER_W'(1);
    end

    always_ff @(posedge clock) begin
        if (accept)      ser_data <= in_data;
        else if (vld_p0) ser_data <= ser_data >> PIX_W;
    end

    // Stage p0 (R): bin the head pixel and issue the scratch read
    always_comb begin
        vld_p0   = (ser_cnt != '0);
        pix_p0   = ser_data[PIX_W-1:0];
        bin_p0   = bin_index(32'(pix_p0), SHIFT);
        addr_p0  = ADDR_W'(bin_p0 / BINS_PER_WORD);
        field_p0 = FIELD_W'(bin_p0 % BINS_PER_WORD);
    end

    always_ff @(posedge clock) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= vld_p0;
    end

    always_ff @(posedge clock) begin
        addr_p1  <= addr_p0;
        field_p1 <= field_p0;
    end

    // Stage p1 (M): forward-select the freshest line and bump one field
    hist_rmw_merge #(
        .CNT_W         (CNT_W),
        .BINS_PER_WORD (BINS_PER_WORD),
        .ADDR_W        (ADDR_W),
        .FIELD_W       (FIELD_W)
    ) u_merge (
        .addr   (addr_p1),
        .rdata  (scr_rdata),
        .w_vld  (vld_p2),
        .w_addr (addr_p2),
        .w_data (data_p2),
        .h_vld  (vld_p3),
        .h_addr (addr_p3),
        .h_data (data_p3),
        .field  (field_p1),
        .wdata  (merged_p1),
        .sat    (sat_p1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    // Stage p2 (W) and p3 history: the p3 copy covers a read that collided
    // with the write of the same line and therefore returned stale data.
    always_ff @(posedge clock) begin
        addr_p2 <= addr_p1;
        data_p2 <= merged_p1;
        addr_p3 <= addr_p2;
        data_p3 <= data_p2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_count <= '0;
            sat_flag    <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            pixel_count <= '0;
            sat_flag    <= 1'b0;
        end else if (vld_p1) begin
            pixel_count <= sat_inc(pixel_count);
            if (sat_p1) sat_flag <= 1'b1;
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign scr_rd_en   = vld_p0;
    assign scr_rd_addr = vld_p0 ? addr_p0 : '0;
    assign scr_wr_en   = (state == ST_CLEAR) || vld_p2;
    assign scr_wr_addr = (state == ST_CLEAR) ? clr_addr : (vld_p2 ? addr_p2 : '0);
    assign scr_wdata   = vld_p2 ? data_p2 : '0;

endmodule

// File: tb/tb_histogram_accum_engine.sv
module tb_histogram_accum_engine;

    logic clock = 1'b0;
    logic reset;

    logic         a_start, a_in_valid, a_in_ready, a_in_last;
    logic [127:0] a_in_data;
    logic         a_rd_en, a_wr_en, a_busy, a_done, a_sat;
    logic [15:0]  a_rd_addr, a_wr_addr;
    logic [127:0] a_rdata, a_wdata;
    logic [31:0]  a_pcnt;

    logic         b_start, b_in_valid, b_in_ready, b_in_last;
    logic [127:0] b_in_data;
    logic         b_rd_en, b_wr_en, b_busy, b_done, b_sat;
    logic [15:0]  b_rd_addr, b_wr_addr;
    logic [15:0]  b_rdata, b_wdata;
    logic [3:0]   b_pcnt;

    typedef struct packed {
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t          sb_q[$];
    int unsigned  model_a [64];
    logic [127:0] mem_a [16];
    logic [15:0]  mem_b [16];
    int           checks = 0;
    int           failures = 0;
    int           a_done_cnt = 0;
    int           b_done_cnt = 0;

    always #5 clock = ~clock;

    histogram_accum_engine dut_a (
        .clock(clock), .reset(reset), .start(a_start),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .scr_rd_en(a_rd_en), .scr_rd_addr(a_rd_addr), .scr_rdata(a_rdata),
        .scr_wr_en(a_wr_en), .scr_wr_addr(a_wr_addr), .scr_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .sat_flag(a_sat), .pixel_count(a_pcnt)
    );

    histogram_accum_engine #(.CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .start(b_start),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .scr_rd_en(b_rd_en), .scr_rd_addr(b_rd_addr), .scr_rdata(b_rdata),
        .scr_wr_en(b_wr_en), .scr_wr_addr(b_wr_addr), .scr_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .sat_flag(b_sat), .pixel_count(b_pcnt)
    );

    // Scratch memories: synchronous read, old data on same-cycle collision.
    always @(posedge clock) begin
        if (a_rd_en) a_rdata <= mem_a[a_rd_addr[3:0]];
        if (a_wr_en) mem_a[a_wr_addr[3:0]] <= a_wdata;
        if (b_rd_en) b_rdata <= mem_b[b_rd_addr[3:0]];
        if (b_wr_en) mem_b[b_wr_addr[3:0]] <= b_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge, score any write on engine A.
    task automatic tick();
        wr_t e;
        @(posedge clock);
        #1;
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        if (a_wr_en) begin
            if (sb_q.size() == 0) begin
                chk("wr_unexpected", a_wr_en, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", a_wr_addr, e.addr);
                chk("wr_data", a_wdata, e.data);
            end
        end
    endtask

    task automatic push_line(input logic [127:0] line);
        wr_t        e;
        logic [7:0] pix;
        int         bin;
        for (int i = 0; i < 16; i++) begin
            pix = line[i*8 +: 8];
            bin = int'(pix >> 2);
            if (model_a[bin] != 32'hFFFF_FFFF) model_a[bin]++;
            e.addr = 16'(bin / 4);
            for (int k = 0; k < 4; k++) e.data[k*32 +: 32] = model_a[(bin / 4) * 4 + k];
            sb_q.push_back(e);
        end
    endtask

    task automatic do_start_a(input bit hold);
        wr_t e;
        for (int i = 0; i < 64; i++) model_a[i] = 0;
        for (int i = 0; i < 16; i++) begin
            e.addr = 16'(i);
            e.data = '0;
            sb_q.push_back(e);
        end
        if (hold) begin
            a_in_valid = 1'b1;
            a_in_data  = {16{8'hFC}};
            a_in_last  = 1'b1;
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("start_busy", a_busy, 1'b1);
        chk("start_pcnt_clr", a_pcnt, 32'd0);
        chk("start_sat_clr", a_sat, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            if (hold) chk("clear_ready_held", a_in_ready, 1'b0);
        end
        chk("clear_last_ready", a_in_ready, 1'b0);
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        tick();
        chk("accum_ready", a_in_ready, 1'b1);
        chk("clear_writes_done", sb_q.size(), 0);
    endtask

    task automatic send_line_a(input logic [127:0] line, input bit last);
        int n = 0;
        while (!a_in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", a_in_ready, 1'b1);
        a_in_valid = 1'b1;
        a_in_data  = line;
        a_in_last  = last;
        push_line(line);
        tick();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic wait_done_a();
        int n = 0;
        int base = a_done_cnt;
        while (a_done_cnt == base && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", a_done_cnt, base + 1);
        repeat (3) tick();
        chk("done_once", a_done_cnt, base + 1);
        chk("idle_busy", a_busy, 1'b0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    task automatic wait_ready_b();
        int n = 0;
        while (!b_in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("b_ready_wait", b_in_ready, 1'b1);
    endtask

    initial begin
        logic [127:0] line;

        reset = 1'b1;
        a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", a_in_ready, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_done", a_done, 1'b0);
        chk("rst_wr_en", a_wr_en, 1'b0);
        chk("rst_rd_en", a_rd_en, 1'b0);
        chk("rst_pcnt", a_pcnt, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_wr_en", a_wr_en, 1'b0);

        // Clear pass then one line of zero pixels
        do_start_a(1'b0);
        send_line_a('0, 1'b1);
        wait_done_a();
        chk("t2_pcnt", a_pcnt, 32'd16);
        chk("t2_field0", mem_a[0][31:0], 32'd16);
        chk("t2_sat", a_sat, 1'b0);

        // Alternating bins 1/0 on the same line exercise both forward paths
        do_start_a(1'b0);
        for (int i = 0; i < 16; i++) line[i*8 +: 8] = (i % 2 == 0) ? 8'h04 : 8'h00;
        send_line_a(line, 1'b1);
        wait_done_a();
        chk("t3_field0", mem_a[0][31:0], 32'd8);
        chk("t3_field1", mem_a[0][63:32], 32'd8);

        // Random two-line frame
        do_start_a(1'b0);
        for (int w = 0; w < 4; w++) line[w*32 +: 32] = $urandom;
        send_line_a(line, 1'b0);
        for (int w = 0; w < 4; w++) line[w*32 +: 32] = $urandom & 32'h1F1F_1F1F;
        send_line_a(line, 1'b1);
        wait_done_a();
        chk("t3r_pcnt", a_pcnt, 32'd32);

        // Reset in the middle of a line aborts at once
        do_start_a(1'b0);
        for (int w = 0; w < 4; w++) line[w*32 +: 32] = $urandom;
        send_line_a(line, 1'b0);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("t5_wr_en", a_wr_en, 1'b0);
        chk("t5_rd_en", a_rd_en, 1'b0);
        chk("t5_wr_addr", a_wr_addr, 16'd0);
        chk("t5_wdata", a_wdata, 128'd0);
        chk("t5_busy", a_busy, 1'b0);
        chk("t5_in_ready", a_in_ready, 1'b0);
        chk("t5_pcnt", a_pcnt, 32'd0);
        sb_q.delete();
        reset = 1'b0;
        tick();
        chk("t5_post_wr_en", a_wr_en, 1'b0);
        do_start_a(1'b0);
        for (int i = 0; i < 16; i++) line[i*8 +: 8] = 8'(i * 16);
        send_line_a(line, 1'b1);
        wait_done_a();
        chk("t5_pcnt_frame", a_pcnt, 32'd16);
        chk("t5_line0", mem_a[0][31:0], 32'd1);
        chk("t5_line15", mem_a[15][31:0], 32'd1);

        // in_valid held through CLEAR and start pulsed during ACCUM are ignored
        do_start_a(1'b1);
        send_line_a('0, 1'b0);
        repeat (3) tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t6_busy", a_busy, 1'b1);
        send_line_a('0, 1'b1);
        wait_done_a();
        chk("t6_pcnt", a_pcnt, 32'd32);
        chk("t6_line0", mem_a[0][31:0], 32'd32);
        chk("t6_line15", mem_a[15], 128'd0);

        // Saturation on the 4-bit counter engine: 20 pixels into bin 63
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_ready_b();
        b_in_valid = 1'b1;
        b_in_data  = {16{8'hFC}};
        b_in_last  = 1'b0;
        tick();
        b_in_valid = 1'b0;
        wait_ready_b();
        b_in_valid = 1'b1;
        b_in_data  = {{12{8'h00}}, {4{8'hFC}}};
        b_in_last  = 1'b1;
        tick();
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        begin
            int n = 0;
            while (b_done_cnt == 0 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("t4_done", b_done_cnt, 1);
        chk("t4_field_sat", mem_b[15][15:12], 4'hF);
        chk("t4_bin0", mem_b[0][3:0], 4'd12);
        chk("t4_sat_flag", b_sat, 1'b1);
        chk("t4_pcnt_sat", b_pcnt, 4'hF);
        repeat (5) tick();
        chk("t4_sat_sticky", b_sat, 1'b1);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("t4_sat_cleared", b_sat, 1'b0);
        chk("t4_pcnt_cleared", b_pcnt, 4'd0);

        chk("sb_final_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
